// File: rtl/regfile.sv
// Architectural RV32I integer register file: one writeback port, two combinational read ports.
// Define ECPU_REGFILE_BYPASS_EN to forward same-cycle writeback data onto matching read ports.
module regfile #(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned REG_ADDR_WIDTH = 5,
    parameter int unsigned CNT_WIDTH      = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [REG_ADDR_WIDTH-1:0] rd_addr_i,
    input  logic [XLEN-1:0]           rd_data_i,
    input  logic                      reg_write_i,
    input  logic [REG_ADDR_WIDTH-1:0] rs1_addr_i,
    input  logic [REG_ADDR_WIDTH-1:0] rs2_addr_i,
    output logic [XLEN-1:0]           rs1_data_o,
    output logic [XLEN-1:0]           rs2_data_o,
    output logic [CNT_WIDTH-1:0]      wr_count_o,
    output logic                      x0_write_o,
    input  logic                      x0_clear_i
);

    localparam int unsigned NUM_REGS = 2 ** REG_ADDR_WIDTH;

    // x0 has no storage; entries start at 1.
    logic [XLEN-1:0]      r_regs [1:NUM_REGS-1];
    logic [CNT_WIDTH-1:0] r_wr_count;
    logic                 r_x0_write;

    logic                 w_rd_is_x0;
    logic                 w_commit;
    logic                 w_x0_attempt;
    logic [XLEN-1:0]      w_rs1_stored;
    logic [XLEN-1:0]      w_rs2_stored;
    logic                 w_rs1_fwd;
    logic                 w_rs2_fwd;

    assign w_rd_is_x0   = (rd_addr_i == '0);
    assign w_commit     = reg_write_i && !w_rd_is_x0;
    assign w_x0_attempt = reg_write_i && w_rd_is_x0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 1; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int unsigned i = 1; i < NUM_REGS; i++) begin
                if (w_commit && (rd_addr_i == REG_ADDR_WIDTH'(i))) begin
                    r_regs[i] <= rd_data_i;
                end
            end
        end
    end

    // Counter wraps naturally at 2**CNT_WIDTH.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_count <= '0;
        end else if (w_commit) begin
            r_wr_count <= r_wr_count + CNT_WIDTH'(1);
        end
    end

    // Set has priority over clear so a same-cycle x0 write is never lost.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_x0_write <= 1'b0;
        end else if (w_x0_attempt) begin
            r_x0_write <= 1'b1;
        end else if (x0_clear_i) begin
            r_x0_write <= 1'b0;
        end
    end

    always_comb begin
        w_rs1_stored = '0;
        w_rs2_stored = '0;
        for (int unsigned i = 1; i < NUM_REGS; i++) begin
            if (rs1_addr_i == REG_ADDR_WIDTH'(i)) begin
                w_rs1_stored = r_regs[i];
            end
            if (rs2_addr_i == REG_ADDR_WIDTH'(i)) begin
                w_rs2_stored = r_regs[i];
            end
        end
    end

`ifdef ECPU_REGFILE_BYPASS_EN
    // w_commit already excludes x0, so address 0 is never forwarded.
    assign w_rs1_fwd = w_commit && (rs1_addr_i == rd_addr_i);
    assign w_rs2_fwd = w_commit && (rs2_addr_i == rd_addr_i);
`else
    assign w_rs1_fwd = 1'b0;
    assign w_rs2_fwd = 1'b0;
`endif

    assign rs1_data_o = w_rs1_fwd ? rd_data_i : w_rs1_stored;
    assign rs2_data_o = w_rs2_fwd ? rd_data_i : w_rs2_stored;
    assign wr_count_o = r_wr_count;
    assign x0_write_o = r_x0_write;

endmodule
